mdu_seq: RTL

Iterative unsigned multiply/divide sequencer that time-shares the core's 32-bit ALU instead of owning its own adder. It holds the HI/LO registers. While a multiply or divide runs, it drives the ALU operand and opcode inputs for 32 consecutive cycles: ADD for shift-add multiply, SUB for restoring divide. The pipeline's EX stage muxes the ALU inputs to this block whenever `busy` is high, and stalls any instruction that needs HI/LO or the ALU during that time.

---
 rtl/mdu_seq.sv | 110 +++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
// Iterative unsigned multiply/divide unit that borrows the core's shared ALU.
// Also holds the HI/LO registers, which mthi and mtlo write directly.
module mdu_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] alu_srcA,
   output logic [31:0] alu_srcB,
   output logic [2:0]  alu_op,
   input  logic [31:0] alu_res
);

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic [31:0] a;
   logic [31:0] q;
   logic [31:0] m;
   logic        k;

   logic [31:0] shifted;
   logic        carry;
   logic        qbit;
   logic [31:0] a_nxt;
   logic [31:0] q_nxt;

   // The ALU result comes back in the same cycle; the 33rd bit of the
   // divide remainder is a[31], which forces a subtract when set.
   always_comb begin
      shifted  = {a[30:0], q[31]};
      carry    = (alu_res < a);
      qbit     = a[31] | (shifted >= m);
      alu_op   = ALU_ADD;
      alu_srcA = 32'd0;
      alu_srcB = 32'd0;
      a_nxt    = {carry, alu_res[31:1]};
      q_nxt    = {alu_res[0], q[31:1]};
      if (state == RUN) begin
         if (k) begin
            alu_op   = ALU_SUB;
            alu_srcA = shifted;
            alu_srcB = m;
            a_nxt    = qbit ? alu_res : shifted;
            q_nxt    = {q[30:0], qbit};
         end else begin
            alu_srcA = a;
            alu_srcB = q[0] ? m : 32'd0;
         end
      end
   end

   // Sequencer: start is only honoured in IDLE, so requests during a run
   // (including mthi/mtlo) are dropped and the issuing stage must hold them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 5'd0;
         a     <= 32'd0;
         q     <= 32'd0;
         m     <= 32'd0;
         k     <= 1'b0;
         busy  <= 1'b0;
         hi    <= 32'd0;
         lo    <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  case (op)
                     2'b00, 2'b01: begin
                        a     <= 32'd0;
                        q     <= rs;
                        m     <= rt;
                        k     <= op[0];
                        cnt   <= 5'd0;
                        busy  <= 1'b1;
                        state <= RUN;
                     end
                     2'b10:   hi <= rs;
                     default: lo <= rs;
                  endcase
               end
            end
            RUN: begin
               a   <= a_nxt;
               q   <= q_nxt;
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  hi    <= a_nxt;
                  lo    <= q_nxt;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
